// File: rtl/bus_arb2_pkg.sv
// Shared definitions for the two-master local-bus arbiter.
// Bus field indices mirror the layout in bus_params.v.
package bus_arb2_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam int unsigned BUS_IN_CLK         = 0;
  localparam int unsigned BUS_IN_RESET_L     = 1;
  localparam int unsigned BUS_IN_RD_REQ      = 2;
  localparam int unsigned BUS_IN_WR_REQ      = 3;
  localparam int unsigned BUS_IN_BE_LSB      = 4;
  localparam int unsigned BUS_IN_ADDR_LSB    = 8;
  localparam int unsigned BUS_IN_WR_DATA_LSB = 40;
  localparam int unsigned BUS_IN_WIDTH       = 72;

  localparam int unsigned BUS_OUT_RD_DATA_LSB = 0;
  localparam int unsigned BUS_OUT_RD_ACK      = 32;
  localparam int unsigned BUS_OUT_WR_ACK      = 33;
  localparam int unsigned BUS_OUT_WIDTH       = 34;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef struct packed {
    logic              wr;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/bus_arb_slot.sv
// One-entry request capture for a single master: pending flag, overflow
// pulse on a request into a full slot, and a clear from the arbiter.
module bus_arb_slot
  import bus_arb2_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic [BUS_IN_WIDTH-1:0] req_bus,
  input  logic                    clr,
  output logic                    pending,
  output req_t                    entry,
  output logic                    overflow
);

  logic req_valid;
  logic unused_ctl;

  assign req_valid  = req_bus[BUS_IN_RD_REQ] | req_bus[BUS_IN_WR_REQ];
  assign unused_ctl = req_bus[BUS_IN_CLK] ^ req_bus[BUS_IN_RESET_L];

  // A clear in the same cycle frees the slot, so that request is accepted.
  assign overflow = reset_l & req_valid & pending & ~clr;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      pending <= 1'b0;
      entry   <= '0;
    end else begin
      if (clr)
        pending <= 1'b0;
      if (req_valid && (!pending || clr)) begin
        pending     <= 1'b1;
        entry.wr    <= req_bus[BUS_IN_WR_REQ];
        entry.be    <= req_bus[BUS_IN_BE_LSB +: BE_W];
        entry.addr  <= req_bus[BUS_IN_ADDR_LSB +: ADDR_W];
        entry.wdata <= req_bus[BUS_IN_WR_DATA_LSB +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter onto the combined local bus, with
// per-master response routing and a synthetic response on slave timeout.
module bus_arb2
  import bus_arb2_pkg::*;
#(
  parameter int unsigned       TIMEOUT      = 1023,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
)
(
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [BUS_IN_WIDTH-1:0]  m0_bus_in,
  output logic [BUS_OUT_WIDTH-1:0] m0_bus_out,
  input  logic [BUS_IN_WIDTH-1:0]  m1_bus_in,
  output logic [BUS_OUT_WIDTH-1:0] m1_bus_out,
  output logic [BUS_IN_WIDTH-1:0]  bus_in,
  input  logic [BUS_OUT_WIDTH-1:0] bus_out,
  output logic                     timeout_err,
  output logic                     overflow_err
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t        state, state_nxt;
  logic              owner, owner_nxt;
  logic              rr_ptr, rr_ptr_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [DATA_W-1:0] resp_data, resp_data_nxt;
  logic [1:0]        pending, clr, ovf;
  req_t              entry0, entry1, cur;
  logic              ack_in;
  logic [BUS_OUT_WIDTH-1:0] resp;

  bus_arb_slot u_slot0 (
    .clk      (clk),
    .reset_l  (reset_l),
    .req_bus  (m0_bus_in),
    .clr      (clr[0]),
    .pending  (pending[0]),
    .entry    (entry0),
    .overflow (ovf[0])
  );

  bus_arb_slot u_slot1 (
    .clk      (clk),
    .reset_l  (reset_l),
    .req_bus  (m1_bus_in),
    .clr      (clr[1]),
    .pending  (pending[1]),
    .entry    (entry1),
    .overflow (ovf[1])
  );

  assign cur          = owner ? entry1 : entry0;
  assign ack_in       = bus_out[BUS_OUT_RD_ACK] | bus_out[BUS_OUT_WR_ACK];
  assign overflow_err = |ovf;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      timer     <= '0;
      resp_data <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      timer     <= timer_nxt;
      resp_data <= resp_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    timer_nxt     = timer;
    resp_data_nxt = resp_data;
    clr           = '0;
    timeout_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (&pending)
          owner_nxt = rr_ptr;
        else if (pending[0])
          owner_nxt = 1'b0;
        else if (pending[1])
          owner_nxt = 1'b1;
        if (|pending)
          state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        timer_nxt = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_in) begin
          resp_data_nxt = bus_out[BUS_OUT_RD_DATA_LSB +: DATA_W];
          state_nxt     = ST_RESP;
        end else if (TIMEOUT != 0 && timer == TW'(TIMEOUT - 1)) begin
          resp_data_nxt = TIMEOUT_DATA;
          timeout_err   = 1'b1;
          state_nxt     = ST_RESP;
        end else if (TIMEOUT != 0) begin
          // With the timeout disabled the timer simply holds.
          timer_nxt = timer + 1'b1;
        end
      end
      ST_RESP: begin
        clr[owner] = 1'b1;
        rr_ptr_nxt = ~owner;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_in                 = '0;
    bus_in[BUS_IN_CLK]     = clk;
    bus_in[BUS_IN_RESET_L] = reset_l;
    if (state == ST_ISSUE || state == ST_WAIT) begin
      bus_in[BUS_IN_BE_LSB +: BE_W]        = cur.be;
      bus_in[BUS_IN_ADDR_LSB +: ADDR_W]    = cur.addr;
      bus_in[BUS_IN_WR_DATA_LSB +: DATA_W] = cur.wdata;
    end
    if (state == ST_ISSUE && reset_l) begin
      bus_in[BUS_IN_RD_REQ] = ~cur.wr;
      bus_in[BUS_IN_WR_REQ] = cur.wr;
    end
  end

  always_comb begin
    resp = '0;
    if (state == ST_RESP) begin
      resp[BUS_OUT_RD_ACK] = ~cur.wr;
      resp[BUS_OUT_WR_ACK] = cur.wr;
      if (!cur.wr)
        resp[BUS_OUT_RD_DATA_LSB +: DATA_W] = resp_data;
    end
    m0_bus_out = owner ? '0 : resp;
    m1_bus_out = owner ? resp : '0;
  end

endmodule

// File: tb/tb_bus_arb2.sv
// Directed bench for bus_arb2: reference slave, event logs and
// hand-computed cycle/data expectations.
module tb_bus_arb2;
  import bus_arb2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_l;
  logic [BUS_IN_WIDTH-1:0]  m0_bus_in, m1_bus_in, bus_in;
  logic [BUS_OUT_WIDTH-1:0] m0_bus_out, m1_bus_out, bus_out;
  logic                     timeout_err, overflow_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bus_arb2 #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .m0_bus_in    (m0_bus_in),
    .m0_bus_out   (m0_bus_out),
    .m1_bus_in    (m1_bus_in),
    .m1_bus_out   (m1_bus_out),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .timeout_err  (timeout_err),
    .overflow_err (overflow_err)
  );

  // Slave: auto mode acks one cycle after the request; manual acks from the stimulus.
  logic        slv_auto = 1'b0;
  logic [31:0] slv_data = '0;
  logic        man_rd = 1'b0, man_wr = 1'b0;
  logic [31:0] man_data = '0;
  logic        auto_rd = 1'b0, auto_wr = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    auto_rd <= slv_auto && bus_in[BUS_IN_RD_REQ] && !bus_in[BUS_IN_WR_REQ];
    auto_wr <= slv_auto && bus_in[BUS_IN_WR_REQ];
  end

  always_comb begin
    bus_out = '0;
    bus_out[BUS_OUT_RD_ACK] = man_rd | auto_rd;
    bus_out[BUS_OUT_WR_ACK] = man_wr | auto_wr;
    if (man_rd || man_wr)
      bus_out[BUS_OUT_RD_DATA_LSB +: 32] = man_data;
    else if (auto_rd)
      bus_out[BUS_OUT_RD_DATA_LSB +: 32] = slv_data;
  end

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
    logic        wr;
  } ev_t;

  ev_t iss_q[$];
  ev_t ack0_q[$];
  ev_t ack1_q[$];
  int  to_q[$];
  int  ov_q[$];

  always @(negedge clk) begin
    if (bus_in[BUS_IN_RD_REQ] || bus_in[BUS_IN_WR_REQ])
      iss_q.push_back(ev_t'{cyc, bus_in[BUS_IN_ADDR_LSB +: 32],
                            bus_in[BUS_IN_WR_DATA_LSB +: 32], bus_in[BUS_IN_WR_REQ]});
    if (m0_bus_out[BUS_OUT_RD_ACK] || m0_bus_out[BUS_OUT_WR_ACK])
      ack0_q.push_back(ev_t'{cyc, 32'h0, m0_bus_out[BUS_OUT_RD_DATA_LSB +: 32],
                             m0_bus_out[BUS_OUT_WR_ACK]});
    if (m1_bus_out[BUS_OUT_RD_ACK] || m1_bus_out[BUS_OUT_WR_ACK])
      ack1_q.push_back(ev_t'{cyc, 32'h0, m1_bus_out[BUS_OUT_RD_DATA_LSB +: 32],
                             m1_bus_out[BUS_OUT_WR_ACK]});
    if (timeout_err)
      to_q.push_back(cyc);
    if (overflow_err)
      ov_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_iss(input int idx, input string tag, input int c,
                         input logic [31:0] a, input logic [31:0] d, input logic wr);
    if (iss_q.size() > idx) begin
      chk({tag, "_cyc"}, iss_q[idx].c, c);
      chk({tag, "_addr"}, iss_q[idx].a, a);
      chk({tag, "_wdata"}, iss_q[idx].d, d);
      chk({tag, "_wr"}, iss_q[idx].wr, wr);
    end else
      chk({tag, "_missing"}, iss_q.size(), idx + 1);
  endtask

  task automatic chk_ack(input int m, input int idx, input string tag, input int c,
                         input logic [31:0] d, input logic wr);
    ev_t e;
    int  n;
    n = (m == 0) ? ack0_q.size() : ack1_q.size();
    if (n > idx) begin
      e = (m == 0) ? ack0_q[idx] : ack1_q[idx];
      chk({tag, "_cyc"}, e.c, c);
      chk({tag, "_data"}, e.d, d);
      chk({tag, "_wr"}, e.wr, wr);
    end else
      chk({tag, "_missing"}, n, idx + 1);
  endtask

  function automatic logic [BUS_IN_WIDTH-1:0] mk(input logic rd, input logic wr,
                                                 input logic [31:0] a, input logic [31:0] d);
    logic [BUS_IN_WIDTH-1:0] v;
    v = '0;
    v[BUS_IN_RD_REQ] = rd;
    v[BUS_IN_WR_REQ] = wr;
    v[BUS_IN_BE_LSB +: 4] = 4'hF;
    v[BUS_IN_ADDR_LSB +: 32] = a;
    v[BUS_IN_WR_DATA_LSB +: 32] = d;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    iss_q.delete();
    ack0_q.delete();
    ack1_q.delete();
    to_q.delete();
    ov_q.delete();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_m0out"}, m0_bus_out, 0);
    chk({tag, "_m1out"}, m1_bus_out, 0);
    chk({tag, "_req"}, {bus_in[BUS_IN_WR_REQ], bus_in[BUS_IN_RD_REQ]}, 0);
    chk({tag, "_addr"}, bus_in[BUS_IN_ADDR_LSB +: 32], 0);
    chk({tag, "_tmo"}, timeout_err, 0);
    chk({tag, "_ovf"}, overflow_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset_l   = 1'b0;
    m0_bus_in = '0;
    m1_bus_in = '0;
    idle(3);
    chk_quiet("rst");
    chk("rst_rstl_field", bus_in[BUS_IN_RESET_L], 0);
    reset_l = 1'b1;
    step();
    chk("rst_clk_field", bus_in[BUS_IN_CLK], 1);
    chk("rst_rstl_rel", bus_in[BUS_IN_RESET_L], 1);

    // Contention, rr_ptr=0 after reset: m0 first, then m1.
    clear_logs();
    slv_auto = 1'b1;
    slv_data = 32'h1234_5678;
    k = cyc;
    m0_bus_in = mk(1'b0, 1'b1, 32'h0200_000C, 32'h5);
    m1_bus_in = mk(1'b1, 1'b0, 32'h0300_0000, 32'h0);
    step();
    m0_bus_in = '0;
    m1_bus_in = '0;
    idle(12);
    chk("c1_niss", iss_q.size(), 2);
    chk_iss(0, "c1_iss0", k + 2, 32'h0200_000C, 32'h5, 1'b1);
    chk_iss(1, "c1_iss1", k + 6, 32'h0300_0000, 32'h0, 1'b0);
    chk_ack(0, 0, "c1_ack0", k + 4, 32'h0, 1'b1);
    chk_ack(1, 0, "c1_ack1", k + 8, 32'h1234_5678, 1'b0);
    chk("c1_nack", ack0_q.size() + ack1_q.size(), 2);

    // Single m0 read; leaves rr_ptr pointing at m1.
    clear_logs();
    slv_data = 32'h017D_7840;
    k = cyc;
    m0_bus_in = mk(1'b1, 1'b0, 32'h0200_0010, 32'h0);
    step();
    m0_bus_in = '0;
    idle(8);
    chk("sr_niss", iss_q.size(), 1);
    chk_iss(0, "sr_iss", k + 2, 32'h0200_0010, 32'h0, 1'b0);
    chk_ack(0, 0, "sr_ack0", k + 4, 32'h017D_7840, 1'b0);
    chk("sr_nack0", ack0_q.size(), 1);
    chk("sr_m1quiet", ack1_q.size(), 0);

    // Contention again with rr_ptr=1: m1 first, then m0.
    clear_logs();
    slv_data = 32'h0BAD_F00D;
    k = cyc;
    m0_bus_in = mk(1'b0, 1'b1, 32'h0200_0008, 32'hA);
    m1_bus_in = mk(1'b1, 1'b0, 32'h0300_0004, 32'h0);
    step();
    m0_bus_in = '0;
    m1_bus_in = '0;
    idle(12);
    chk_iss(0, "c2_iss0", k + 2, 32'h0300_0004, 32'h0, 1'b0);
    chk_iss(1, "c2_iss1", k + 6, 32'h0200_0008, 32'hA, 1'b1);
    chk_ack(1, 0, "c2_ack1", k + 4, 32'h0BAD_F00D, 1'b0);
    chk_ack(0, 0, "c2_ack0", k + 8, 32'h0, 1'b1);

    // Timeout on m1, then a stray ack three cycles after the response.
    clear_logs();
    slv_auto = 1'b0;
    k = cyc;
    m1_bus_in = mk(1'b1, 1'b0, 32'h0F00_0000, 32'h0);
    step();
    m1_bus_in = '0;
    idle(13);
    man_rd   = 1'b1;
    man_data = 32'h0BAD_BADB;
    step();
    man_rd = 1'b0;
    idle(5);
    chk("to_npulse", to_q.size(), 1);
    if (to_q.size() > 0)
      chk("to_cyc", to_q[0], k + 10);
    chk("to_niss", iss_q.size(), 1);
    chk_iss(0, "to_iss", k + 2, 32'h0F00_0000, 32'h0, 1'b0);
    chk_ack(1, 0, "to_ack1", k + 11, 32'hDEAD_BEEF, 1'b0);
    chk("to_nack1", ack1_q.size(), 1);
    chk("to_nack0", ack0_q.size(), 0);

    // Ack lands exactly when timer==TIMEOUT-1: normal response wins.
    clear_logs();
    k = cyc;
    m1_bus_in = mk(1'b1, 1'b0, 32'h0300_0008, 32'h0);
    step();
    m1_bus_in = '0;
    idle(9);
    man_rd   = 1'b1;
    man_data = 32'h55AA_55AA;
    #1;
    chk("ac_no_tmo_now", timeout_err, 0);
    step();
    man_rd = 1'b0;
    idle(4);
    chk("ac_npulse", to_q.size(), 0);
    chk_ack(1, 0, "ac_ack1", k + 11, 32'h55AA_55AA, 1'b0);

    // Overflow while pending, then a new request in the RESP cycle.
    clear_logs();
    k = cyc;
    m0_bus_in = mk(1'b1, 1'b0, 32'h0200_0020, 32'h0);
    step();
    m0_bus_in = '0;
    idle(2);
    m0_bus_in = mk(1'b1, 1'b0, 32'h0200_0024, 32'h0);
    #1;
    chk("ov_now", overflow_err, 1);
    step();
    m0_bus_in = '0;
    step();
    chk("ov_hold_addr", bus_in[BUS_IN_ADDR_LSB +: 32], 32'h0200_0020);
    man_rd   = 1'b1;
    man_data = 32'h1111_2222;
    step();
    man_rd    = 1'b0;
    m0_bus_in = mk(1'b0, 1'b1, 32'h0200_0030, 32'h7);
    slv_auto  = 1'b1;
    step();
    m0_bus_in = '0;
    idle(8);
    chk("ov_npulse", ov_q.size(), 1);
    if (ov_q.size() > 0)
      chk("ov_cyc", ov_q[0], k + 3);
    chk("ov_niss", iss_q.size(), 2);
    chk_iss(0, "ov_iss0", k + 2, 32'h0200_0020, 32'h0, 1'b0);
    chk_iss(1, "ov_iss1", k + 8, 32'h0200_0030, 32'h7, 1'b1);
    chk_ack(0, 0, "ov_ack0", k + 6, 32'h1111_2222, 1'b0);
    chk_ack(0, 1, "ov_ack1", k + 10, 32'h0, 1'b1);

    // Reset during WAIT with m1 pending (rr_ptr was 1 before reset).
    clear_logs();
    slv_auto = 1'b0;
    k = cyc;
    m0_bus_in = mk(1'b1, 1'b0, 32'h0200_0040, 32'h0);
    step();
    m0_bus_in = '0;
    m1_bus_in = mk(1'b1, 1'b0, 32'h0300_0010, 32'h0);
    step();
    m1_bus_in = '0;
    idle(2);
    reset_l = 1'b0;
    step();
    reset_l = 1'b1;
    chk_quiet("mr");
    man_rd   = 1'b1;
    man_data = 32'h0000_0077;
    step();
    man_rd = 1'b0;
    idle(6);
    chk("mr_niss", iss_q.size(), 1);
    chk("mr_nack0", ack0_q.size(), 0);
    chk("mr_nack1", ack1_q.size(), 0);

    // rr_ptr back to 0: contention serves m0 first.
    clear_logs();
    slv_auto = 1'b1;
    slv_data = 32'h0000_CAFE;
    k = cyc;
    m0_bus_in = mk(1'b0, 1'b1, 32'h0200_0050, 32'h1);
    m1_bus_in = mk(1'b1, 1'b0, 32'h0300_0014, 32'h0);
    step();
    m0_bus_in = '0;
    m1_bus_in = '0;
    idle(12);
    chk_iss(0, "pr_iss0", k + 2, 32'h0200_0050, 32'h1, 1'b1);
    chk_iss(1, "pr_iss1", k + 6, 32'h0300_0014, 32'h0, 1'b0);
    chk_ack(1, 0, "pr_ack1", k + 8, 32'h0000_CAFE, 1'b0);

    // Lone m1 request served normally.
    clear_logs();
    slv_data = 32'h0000_FACE;
    k = cyc;
    m1_bus_in = mk(1'b1, 1'b0, 32'h0300_0018, 32'h0);
    step();
    m1_bus_in = '0;
    idle(8);
    chk_iss(0, "m1_iss", k + 2, 32'h0300_0018, 32'h0, 1'b0);
    chk_ack(1, 0, "m1_ack", k + 4, 32'h0000_FACE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
